// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// one-entry holding register with valid/ack handshake plus error reporting.
module uart_rx #(
    parameter int clock_freq = 50000000,
    parameter int baud_rate  = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_error,
    output logic       overrun
);

    localparam int DIV   = clock_freq / baud_rate;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx: clock_freq/baud_rate must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_error_q, frame_error_d;
    logic             overrun_q, overrun_d;
    logic             rx_meta_q, rx_s_q;
    logic             deliver;

    // NOTE: the synchroniser resets to the idle line level (1) so that
    // leaving reset never looks like a start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let both flops sample the
            // pre-edge values, giving a true two-stage shift.
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        frame_error_d = 1'b0;
        deliver       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An ack on the delivery cycle frees the slot in time for the new byte.
    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;

        if (data_valid_q && data_ack) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end

        if (deliver) begin
            if (!data_valid_q || data_ack) begin
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=10/HALF=5: expected bytes are queued
// as frames are driven and compared whenever data_valid rises.
module tb_uart_rx;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int BIT_CYC  = 10;
    // Start drive to data_valid visible: 2 sync + 1 IDLE + HALF + 8*DIV + DIV.
    localparam int DV_LATENCY = 98;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack = 1'b0;
    logic       frame_error;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    int fe_count = 0;
    int ack_reqs = 0;
    int ack_done = 0;
    bit auto_ack = 1'b0;
    bit pend_auto = 1'b0;
    bit prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .clock_freq(CLK_FREQ),
        .baud_rate (BAUD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pops on each data_valid rise; also owns data_ack.
    initial begin
        forever begin
            @(negedge clock);
            data_ack = 1'b0;
            if (pend_auto) begin
                data_ack  = 1'b1;
                pend_auto = 1'b0;
            end else if (ack_reqs != ack_done) begin
                data_ack = 1'b1;
                ack_done++;
            end
            if (data_valid && !prev_valid) begin
                rise_cyc = cyc;
                check("sb_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) check("sb_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
                if (auto_ack) pend_auto = 1'b1;
            end
            if (frame_error) fe_count++;
            prev_valid = data_valid;
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit expect_it);
        @(negedge clock);
        #1;
        start_cyc = cyc;
        if (expect_it) exp_q.push_back(b);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clock);
        end
        rx = stop_bit;
        repeat (BIT_CYC) @(negedge clock);
        rx = 1'b1;
    endtask

    // Requests one ack pulse; the monitor drives it on the next falling edge.
    task automatic ack_and_check(input string tag);
        @(negedge clock);
        #1;
        ack_reqs++;
        @(negedge clock);
        #1;
        check({tag, "_dv_before"}, {31'd0, data_valid}, 32'd1);
        @(negedge clock);
        #1;
        check({tag, "_dv_after"}, {31'd0, data_valid}, 32'd0);
        check({tag, "_ovr_after"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe_base;
        #12;
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_error}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // Single frame, no ack: exact delivery latency.
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (5) @(negedge clock);
        check("a5_latency", rise_cyc - start_cyc, DV_LATENCY);
        check("a5_data_out", {24'd0, data_out}, 32'h0000_00A5);
        check("a5_ovr", {31'd0, overrun}, 32'd0);
        check("a5_ferr_cnt", fe_count, 0);
        ack_and_check("a5");

        // Back-to-back frames with auto-ack.
        auto_ack = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1);
        repeat (5) @(negedge clock);
        auto_ack = 1'b0;
        check("b2b_ovr", {31'd0, overrun}, 32'd0);
        check("b2b_valid", {31'd0, data_valid}, 32'd0);

        // Overrun: second byte dropped, first byte held.
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (5) @(negedge clock);
        check("ovr_data_out", {24'd0, data_out}, 32'h0000_0011);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        ack_and_check("ovr");

        // Framing error followed by a long break.
        fe_base = fe_count;
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40 * BIT_CYC) @(negedge clock);
        rx = 1'b1;
        repeat (20) @(negedge clock);
        check("brk_ferr_cnt", fe_count - fe_base, 1);
        check("brk_valid", {31'd0, data_valid}, 32'd0);
        send_frame(8'h0F, 1'b1, 1'b1);
        repeat (5) @(negedge clock);
        check("post_brk_valid", {31'd0, data_valid}, 32'd1);
        ack_and_check("brk");

        // Short glitch on idle line is rejected.
        @(negedge clock);
        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (30) @(negedge clock);
        check("glitch_valid", {31'd0, data_valid}, 32'd0);
        check("glitch_ferr_cnt", fe_count - fe_base, 1);
        send_frame(8'h80, 1'b1, 1'b1);
        repeat (5) @(negedge clock);
        check("post_glitch_valid", {31'd0, data_valid}, 32'd1);

        // Reset in the middle of data bit 4, with 0x80 still held.
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (1 + BIT_CYC + 4 * BIT_CYC + 5) @(negedge clock);
                #2;
                reset = 1'b0;
                #1;
                check("mid_rst_data_out", {24'd0, data_out}, 32'd0);
                check("mid_rst_valid", {31'd0, data_valid}, 32'd0);
                check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
                check("mid_rst_ferr", {31'd0, frame_error}, 32'd0);
            end
        join
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        send_frame(8'h01, 1'b1, 1'b1);
        repeat (5) @(negedge clock);
        check("post_rst_valid", {31'd0, data_valid}, 32'd1);
        ack_and_check("rst");

        repeat (10) @(negedge clock);
        check("sb_drained", exp_q.size(), 0);
        check("total_ferr", fe_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the host-to-board direction of the UART link.
- The board UART_TXD pin is currently unused; this block consumes it and complements the transmit path inside generator.
- Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) by mid-bit sampling from a free-running bit-period counter.
- Delivers each byte through a one-entry holding register with valid/ack handshake; reports framing and overrun errors.
- Instantiated in the sys_clk domain next to generator, with the same clock_freq parameter.

Parameters:
- clock_freq, 50000000, clock frequency in Hz.
- baud_rate, 115200, line rate in bit/s.
- Derived constants:
  - DIV = clock_freq/baud_rate, integer truncation (434 at defaults).
  - HALF = DIV/2, truncated.
  - DIV must be >= 4; elaboration-time error otherwise.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idle high; asynchronous to clock.
- data_out  output  8  last received byte.
- data_valid  output  1  holding register full.
- data_ack  input  1  consumer takes the byte; honoured only while data_valid=1.
- frame_error  output  1  one-cycle pulse when a stop bit samples 0.
- overrun  output  1  sticky flag: a complete byte was dropped because the holding register was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0x00, data_valid=0, frame_error=0, overrun=0.
  - FSM goes to IDLE; both synchroniser flops load 1; bit counter and bit index load 0.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s only, which adds 2 cycles of latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s=0, go to START with cnt=0.
  - START: count; at cnt=HALF-1, sample rx_s.
    - rx_s=0: go to DATA, cnt=0, idx=0.
    - rx_s=1: glitch; return to IDLE with no output activity.
  - DATA: at cnt=DIV-1, sample rx_s into shift[idx] (LSB first) and reset cnt. After idx=7 is sampled, go to STOP.
  - STOP: at cnt=DIV-1, sample rx_s.
    - rx_s=1: deliver the byte, go to IDLE.
    - rx_s=0: assert frame_error for exactly 1 cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. A held-low line (break) therefore yields exactly one frame_error, not repeated frames.
- Delivery occurs on the cycle after the stop-bit sample point:
  - If data_valid=0, or data_ack=1 on that same cycle: data_out <= shift, data_valid <= 1. No overrun.
  - If data_valid=1 and data_ack=0: the new byte is dropped, data_out is unchanged, overrun <= 1.
- Handshake:
  - data_ack=1 while data_valid=1 clears data_valid on the next edge and clears overrun on the same edge.
  - data_ack while data_valid=0 is ignored.
  - data_out is stable whenever data_valid=1.
- Counter: cnt width = clog2(DIV). It never exceeds DIV-1, so there is no wrap-around hazard.
- Back-to-back frames: a start edge seen in IDLE immediately after delivery is accepted. No inter-frame idle time is required beyond the stop bit.
- Reset mid-frame: the partial frame is lost and no pulse is generated. After reset, a line already low is treated as a start bit only once HALF samples confirm it.

Test Plan:
Bench uses clock_freq=1000000, baud_rate=100000, giving DIV=10 and HALF=5.
- Single frame 0xA5 with data_ack held 0 -> data_valid rises 1 cycle after the stop sample; data_out=0xA5; frame_error and overrun stay 0.
- Frames 0x3C then 0xC3 back-to-back, with data_ack pulsed 1 cycle after each data_valid -> two deliveries, exact values, no overrun.
- Two frames 0x11, 0x22 with no ack -> data_out stays 0x11, overrun=1. A later data_ack clears both data_valid and overrun on the next edge.
- Frame 0x55 with stop bit driven 0, then line held low for 40 bit times -> exactly one frame_error pulse, data_valid stays 0. After the line returns high, frame 0x0F is received correctly.
- 3-cycle low glitch on an idle line -> no delivery, no error, FSM back in IDLE. A following frame 0x80 decodes to 0x80.
- reset asserted at data bit 4 of frame 0xFF -> outputs go to their reset values immediately. A next full frame 0x01 is received correctly.
